mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter_if.sv | 23 ++
 rtl/mult_arbiter.sv | 72 +++++++
 2 files changed

// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: requester handshake and shared-multiplier bus for mult_arbiter.
interface mult_arbiter_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    ack;
  logic [N_REQ*16-1:0] op_a;
  logic [N_REQ*16-1:0] op_b;
  logic [31:0]         result;
  logic                err;
  logic                busy;
  logic                mult_init;
  logic [15:0]         mult_a;
  logic [15:0]         mult_b;
  logic [31:0]         mult_pp;
  logic                mult_done;
  modport master (
    input  req, op_a, op_b, mult_pp, mult_done,
    output ack, result, err, busy, mult_init, mult_a, mult_b
  );
  modport slave (
    output req, op_a, op_b, mult_pp, mult_done,
    input  ack, result, err, busy, mult_init, mult_a, mult_b
  );
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter sharing one 16x16 multiplier among N_REQ requesters.
module mult_arbiter #(
  parameter int N_REQ    = 4,
  parameter int INIT_CYC = 2,
  parameter int TIMEOUT  = 255
) (
  input logic clk,
  input logic rst,
  mult_arbiter_if.master bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(INIT_CYC + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DELIVER} state_t;
  state_t state, nxt;
  logic [IW-1:0] grant_idx, last_idx, win;
  logic [CW-1:0] wcnt;
  logic [LW-1:0] icnt;
  logic timed_out, take, expire;
  // walk the ring backwards so the first requester after last_idx wins
  always_comb begin
    win = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (bus.req[(int'(last_idx) + 1 + k) % N_REQ]) win = IW'((int'(last_idx) + 1 + k) % N_REQ);
  end
  // a done level left over from the previous operation is never taken in the first WAIT cycle
  assign take   = state == WAIT && wcnt != '0 && bus.mult_done;
  assign expire = state == WAIT && !take && wcnt == CW'(TIMEOUT - 1);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = |bus.req ? LAUNCH : IDLE;
      LAUNCH:  nxt = icnt == LW'(INIT_CYC - 1) ? WAIT : LAUNCH;
      WAIT:    nxt = take || expire ? DELIVER : WAIT;
      DELIVER: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bus.result <= '0;
      bus.mult_a <= '0;
      bus.mult_b <= '0;
      grant_idx  <= '0;
      last_idx   <= IW'(N_REQ - 1);
      icnt       <= '0;
      wcnt       <= '0;
      timed_out  <= 1'b0;
    end else begin
      state <= nxt;
      icnt  <= state == LAUNCH ? icnt + 1'b1 : '0;
      wcnt  <= state == WAIT ? wcnt + 1'b1 : '0;
      if (state == IDLE && |bus.req) begin
        bus.mult_a <= bus.op_a[16*int'(win) +: 16];
        bus.mult_b <= bus.op_b[16*int'(win) +: 16];
        grant_idx  <= win;
        timed_out  <= 1'b0;
      end
      if (take) bus.result <= bus.mult_pp;
      if (expire) begin
        bus.result <= '1;
        timed_out  <= 1'b1;
      end
      if (take || expire) last_idx <= grant_idx;
    end
  end
  assign bus.busy      = state != IDLE;
  assign bus.mult_init = state == LAUNCH;
  assign bus.ack       = state == DELIVER ? {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx : '0;
  assign bus.err       = state == DELIVER && timed_out;
endmodule
